// File: rtl/ps2_line_buffer.sv
// PS/2 line buffer: accumulates typed characters into a text line, requests a
// screen draw per accepted character and commits finished lines to a history.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   input_character       cleaned ASCII code, valid with input_made strobe
//   vga_write_done        display writer finished the current draw request
//   hist_sel              history index (0 = most recent committed line)
//   vga_character_in      character to draw at row_num/col_num
//   row_num, col_num      draw position; col_num doubles as the cursor
//   vga_start_write       draw request, held high until vga_write_done
//   line_content          last committed line, char 0 in the top byte
//   line_ready            one-cycle strobe when line_content is updated
//   hist_line             history line selected by hist_sel (blank if unused)
//   hist_count            number of valid history entries
//   busy                  high while drawing or committing
//   dropped_count         saturating count of discarded inputs
module ps2_line_buffer #(
    parameter int LINE_CHARS = 32,
    parameter int ROWS       = 16,
    parameter int HIST_DEPTH = 4,
    localparam int HW        = $clog2(HIST_DEPTH),
    localparam int LW        = LINE_CHARS * 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    input_character,
    input  logic          input_made,
    input  logic          vga_write_done,
    input  logic [HW-1:0] hist_sel,
    output logic [7:0]    vga_character_in,
    output logic [7:0]    row_num,
    output logic [7:0]    col_num,
    output logic          vga_start_write,
    output logic [LW-1:0] line_content,
    output logic          line_ready,
    output logic [LW-1:0] hist_line,
    output logic [HW:0]   hist_count,
    output logic          busy,
    output logic [7:0]    dropped_count
);

    localparam logic [LW-1:0] BLANK    = {LINE_CHARS{8'h20}};
    localparam logic [7:0]    MAX_COL  = 8'(LINE_CHARS);
    localparam logic [7:0]    LAST_ROW = 8'(ROWS - 1);
    localparam logic [HW:0]   FULL     = (HW + 1)'(HIST_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [LW-1:0] line_q;
    logic [LW-1:0] hist_mem [HIST_DEPTH];
    logic [HW-1:0] wr_ptr;
    logic [HW-1:0] rd_idx;
    logic          inc_pending;

    logic          is_print;
    logic          do_print;
    logic          do_bs;
    logic          do_enter;
    logic          do_drop;
    logic          do_done;
    logic          line_we;
    logic [7:0]    line_wcol;
    logic [7:0]    line_wdata;

    assign is_print = (input_character >= 8'h20) && (input_character <= 8'h7E);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_print   = 1'b0;
        do_bs      = 1'b0;
        do_enter   = 1'b0;
        do_drop    = 1'b0;
        do_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (input_made) begin
                    if (is_print) begin
                        if (col_num >= MAX_COL) begin
                            do_drop = 1'b1;
                        end else begin
                            do_print   = 1'b1;
                            state_next = DRAW;
                        end
                    end else if (input_character == 8'h08) begin
                        if (col_num != 8'd0) begin
                            do_bs      = 1'b1;
                            state_next = DRAW;
                        end
                    end else if (input_character == 8'h0D) begin
                        do_enter   = 1'b1;
                        state_next = COMMIT;
                    end
                end
            end
            DRAW: begin
                // Anything typed while a draw is pending is lost, even in
                // the cycle the writer reports completion.
                do_drop = input_made;
                if (vga_write_done) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                do_drop    = input_made;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Printable chars land at the cursor; backspace blanks the cell left of it.
    always_comb begin
        line_we    = do_print | do_bs;
        line_wcol  = do_bs ? (col_num - 8'd1) : col_num;
        line_wdata = do_bs ? 8'h20 : input_character;
    end

    assign vga_start_write = (state == DRAW);
    assign line_ready      = (state == COMMIT);
    assign busy            = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_q           <= BLANK;
            line_content     <= BLANK;
            vga_character_in <= 8'h00;
            row_num          <= 8'd0;
            col_num          <= 8'd0;
            dropped_count    <= 8'd0;
            hist_count       <= '0;
            wr_ptr           <= '0;
            inc_pending      <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_mem[i] <= BLANK;
            end
        end else begin
            for (int i = 0; i < LINE_CHARS; i++) begin
                if (line_we && (line_wcol == 8'(i))) begin
                    line_q[(LINE_CHARS-1-i)*8 +: 8] <= line_wdata;
                end
            end
            if (do_print) begin
                vga_character_in <= input_character;
                inc_pending      <= 1'b1;
            end
            if (do_bs) begin
                vga_character_in <= 8'h20;
                col_num          <= col_num - 8'd1;
                inc_pending      <= 1'b0;
            end
            // The cursor only advances once the glyph is actually on screen.
            if (do_done && inc_pending) begin
                col_num <= col_num + 8'd1;
            end
            if (do_enter) begin
                line_content     <= line_q;
                hist_mem[wr_ptr] <= line_q;
                wr_ptr           <= wr_ptr + HW'(1);
                if (hist_count != FULL) hist_count <= hist_count + 1'b1;
                line_q  <= BLANK;
                col_num <= 8'd0;
                row_num <= (row_num == LAST_ROW) ? 8'd0 : row_num + 8'd1;
            end
            if (do_drop && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end
    end

    // wr_ptr points at the next free slot, so the newest entry is one behind.
    always_comb begin
        rd_idx = wr_ptr - HW'(1) - hist_sel;
        if ({1'b0, hist_sel} < hist_count) hist_line = hist_mem[rd_idx];
        else                               hist_line = BLANK;
    end

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Randomized bench for ps2_line_buffer against a line/history model.
// Small geometry (4 chars, 2 rows, 4 history entries) to reach edge cases.
module tb_ps2_line_buffer;

    localparam int LC = 4;
    localparam int NR = 2;
    localparam int HD = 4;
    localparam int HW = 2;
    localparam int LW = LC * 8;
    localparam logic [LW-1:0] BLANK = {LC{8'h20}};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    input_character = 8'h00;
    logic          input_made = 1'b0;
    logic          vga_write_done = 1'b0;
    logic [HW-1:0] hist_sel = '0;
    logic [7:0]    vga_character_in;
    logic [7:0]    row_num;
    logic [7:0]    col_num;
    logic          vga_start_write;
    logic [LW-1:0] line_content;
    logic          line_ready;
    logic [LW-1:0] hist_line;
    logic [HW:0]   hist_count;
    logic          busy;
    logic [7:0]    dropped_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]    mline [LC];
    int            mcol;
    int            mrow;
    int            mdrop;
    logic [LW-1:0] mhist [$];
    int            inj_mode;

    ps2_line_buffer #(
        .LINE_CHARS(LC),
        .ROWS      (NR),
        .HIST_DEPTH(HD)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .input_character (input_character),
        .input_made      (input_made),
        .vga_write_done  (vga_write_done),
        .hist_sel        (hist_sel),
        .vga_character_in(vga_character_in),
        .row_num         (row_num),
        .col_num         (col_num),
        .vga_start_write (vga_start_write),
        .line_content    (line_content),
        .line_ready      (line_ready),
        .hist_line       (hist_line),
        .hist_count      (hist_count),
        .busy            (busy),
        .dropped_count   (dropped_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LC; i++) r[(LC-1-i)*8 +: 8] = mline[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LC; i++) mline[i] = 8'h20;
        mcol  = 0;
        mrow  = 0;
        mdrop = 0;
        mhist.delete();
    endtask

    task automatic bump_drop();
        if (mdrop < 255) mdrop++;
    endtask

    task automatic check_reset();
        check("rst_req", 64'(vga_start_write), 0);
        check("rst_rdy", 64'(line_ready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_row", 64'(row_num), 0);
        check("rst_col", 64'(col_num), 0);
        check("rst_char", 64'(vga_character_in), 0);
        check("rst_drop", 64'(dropped_count), 0);
        check("rst_hcnt", 64'(hist_count), 0);
        check("rst_line", 64'(line_content), 64'(BLANK));
        hist_sel = '0;
        #1;
        check("rst_hist", 64'(hist_line), 64'(BLANK));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_hist();
        logic [LW-1:0] exp;
        check("hist_cnt", 64'(hist_count), 64'(mhist.size()));
        for (int s = 0; s < HD; s++) begin
            hist_sel = HW'(s);
            #1;
            exp = (s < mhist.size()) ? mhist[s] : BLANK;
            check("hist_line", 64'(hist_line), 64'(exp));
        end
    endtask

    task automatic do_draw(input logic [7:0] ch, input int col, input int waits);
        int hi;
        bit inj;
        hi = 0;
        check("req_on", 64'(vga_start_write), 1);
        check("draw_ch", 64'(vga_character_in), 64'(ch));
        check("draw_col", 64'(col_num), 64'(col));
        check("draw_row", 64'(row_num), 64'(mrow));
        check("busy_draw", 64'(busy), 1);
        hi += int'(vga_start_write);
        for (int i = 0; i < waits; i++) begin
            inj = (inj_mode == 2 && i == 0) ||
                  (inj_mode == 1 && $urandom % 3 == 0);
            if (inj) begin
                input_character = 8'($urandom);
                input_made = 1'b1;
            end
            @(negedge clock);
            input_made = 1'b0;
            if (inj) bump_drop();
            check("req_hold", 64'(vga_start_write), 1);
            check("ch_hold", 64'(vga_character_in), 64'(ch));
            check("col_hold", 64'(col_num), 64'(col));
            hi += int'(vga_start_write);
        end
        inj = (inj_mode == 2 && waits == 0) ||
              (inj_mode == 1 && $urandom % 3 == 0);
        vga_write_done = 1'b1;
        if (inj) begin
            input_character = 8'($urandom);
            input_made = 1'b1;
        end
        @(negedge clock);
        vga_write_done = 1'b0;
        input_made = 1'b0;
        if (inj) bump_drop();
        check("req_len", 64'(hi), 64'(waits + 1));
        check("req_off", 64'(vga_start_write), 0);
        check("busy_off", 64'(busy), 0);
        check("drop_draw", 64'(dropped_count), 64'(mdrop));
    endtask

    task automatic send(input logic [7:0] ch, input int waits);
        logic [LW-1:0] exp;
        bit inj;
        @(negedge clock);
        input_character = ch;
        input_made = 1'b1;
        @(negedge clock);
        input_made = 1'b0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            if (mcol < LC) begin
                mline[mcol] = ch;
                do_draw(ch, mcol, waits);
                mcol++;
            end else begin
                bump_drop();
                check("full_req", 64'(vga_start_write), 0);
            end
            check("col", 64'(col_num), 64'(mcol));
            check("drop", 64'(dropped_count), 64'(mdrop));
        end else if (ch == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                mline[mcol] = 8'h20;
                do_draw(8'h20, mcol, waits);
            end else begin
                check("bs0_req", 64'(vga_start_write), 0);
            end
            check("bs_col", 64'(col_num), 64'(mcol));
            check("bs_drop", 64'(dropped_count), 64'(mdrop));
        end else if (ch == 8'h0D) begin
            exp = pack_line();
            check("rdy_on", 64'(line_ready), 1);
            check("commit", 64'(line_content), 64'(exp));
            check("busy_cm", 64'(busy), 1);
            mhist.push_front(exp);
            if (mhist.size() > HD) void'(mhist.pop_back());
            for (int i = 0; i < LC; i++) mline[i] = 8'h20;
            mcol = 0;
            mrow = (mrow + 1) % NR;
            check("cm_row", 64'(row_num), 64'(mrow));
            check("cm_col", 64'(col_num), 0);
            inj = (inj_mode == 2) || (inj_mode == 1 && $urandom % 2 == 0);
            if (inj) begin
                input_character = 8'($urandom);
                input_made = 1'b1;
            end
            @(negedge clock);
            input_made = 1'b0;
            if (inj) bump_drop();
            check("rdy_off", 64'(line_ready), 0);
            check("cm_busy", 64'(busy), 0);
            check("cm_hold", 64'(line_content), 64'(exp));
            check("cm_drop", 64'(dropped_count), 64'(mdrop));
            check_hist();
        end else begin
            check("oth_req", 64'(vga_start_write), 0);
            check("oth_busy", 64'(busy), 0);
            check("oth_col", 64'(col_num), 64'(mcol));
            check("oth_drop", 64'(dropped_count), 64'(mdrop));
        end
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] other [7];
        other = '{8'h00, 8'h07, 8'h0A, 8'h1B, 8'h7F, 8'h80, 8'hFF};
        case ($urandom % 8)
            4:       return 8'h08;
            5:       return 8'h0D;
            6:       return other[$urandom % 7];
            default: return 8'($urandom_range(8'h20, 8'h7E));
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

    initial begin
        int rows [5];
        int exp_rows [5];
        exp_rows = '{1, 0, 1, 0, 1};
        inj_mode = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_reset();
        reset = 1'b0;

        // two chars, three-cycle draws
        send(8'h41, 2);
        send(8'h42, 2);
        check("ab_col", 64'(col_num), 2);

        // backspace then enter commits "A"
        send(8'h08, 1);
        send(8'h0D, 0);
        check("a_line", 64'(line_content), 64'(32'h41202020));
        check("a_row", 64'(row_num), 1);
        check("a_col", 64'(col_num), 0);

        // overflow and drop during draw
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 0);
        check("ovf_drop", 64'(dropped_count), 1);
        check("ovf_col", 64'(col_num), 4);
        inj_mode = 2;
        send(8'h08, 1);
        inj_mode = 0;
        check("busy_drop", 64'(dropped_count), 2);
        send(8'h08, 0);
        send(8'h08, 0);
        send(8'h08, 0);
        send(8'h08, 0);
        check("bs_c0", 64'(col_num), 0);
        send(8'h0D, 0);

        // history wrap and row wrap
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(8'h31 + 8'(k), 0);
            send(8'h0D, 0);
            rows[k] = int'(row_num);
            check("row_seq", 64'(rows[k]), 64'(exp_rows[k]));
        end
        check("h_cnt", 64'(hist_count), 4);
        hist_sel = 2'd0;
        #1;
        check("h_sel0", 64'(hist_line), 64'(32'h35202020));
        hist_sel = 2'd3;
        #1;
        check("h_sel3", 64'(hist_line), 64'(32'h32202020));

        // reset in the middle of a draw
        do_reset();
        @(negedge clock);
        input_character = 8'h41;
        input_made = 1'b1;
        @(negedge clock);
        input_made = 1'b0;
        check("pre_rst", 64'(vga_start_write), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        send(8'h43, 1);

        // random traffic
        do_reset();
        inj_mode = 1;
        repeat (400) send(rand_char(), int'($urandom_range(0, 3)));
        check_hist();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
